// File: rtl/sha_mem_pkg.sv
// Shared types for the hashing engine's memory responder.
// Host FSM states, bus word/address types and default fill data.
package sha_mem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [1:0] {
    H_IDLE,
    H_ARB,
    H_ACK
  } host_state_e;

  localparam word_t OOR_DATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/sha_mem_responder_res_tracker.sv
// Marks result-window words as the engine writes them.
// Pulses res_done once the whole window is filled, then re-arms.
module res_tracker
  import sha_mem_pkg::*;
#(
  parameter addr_t RES_ADDR = 16'h0080,
  parameter int    NUM_RES  = 16
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  wr,
  input  addr_t addr,
  output logic  res_done
);

  localparam addr_t NRES = addr_t'(NUM_RES);

  addr_t              off;
  logic               hit;
  logic [NUM_RES-1:0] bitmap;
  logic [NUM_RES-1:0] set;
  logic [NUM_RES-1:0] nxt;

  assign off = addr - RES_ADDR;
  assign hit = wr && (off < NRES);
  assign set = hit ? (NUM_RES'(1) << off[4:0]) : '0;
  assign nxt = bitmap | set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitmap   <= '0;
      res_done <= 1'b0;
    end else if (&nxt) begin
      bitmap   <= '0;
      res_done <= 1'b1;
    end else begin
      bitmap   <= nxt;
      res_done <= 1'b0;
    end
  end

endmodule

// File: rtl/sha_mem_responder.sv
// Word memory on the hash engine bus with a host side port.
// The bus is never stalled; the host waits for a quiet bus cycle.
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter addr_t BASE_ADDR = 16'h0000,
  parameter addr_t RES_ADDR  = 16'h0080,
  parameter int    NUM_RES   = 16,
  parameter word_t OOR_DATA  = OOR_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        res_done,
  output logic        oor_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  word_t       mem [DEPTH];
  addr_t       bus_idx;
  addr_t       host_idx;
  addr_t       last_addr;
  logic        bus_in;
  logic        host_in;
  logic        bus_active;
  logic        host_go;
  host_state_e state_q;
  host_state_e state_d;

  assign bus_idx    = mem_addr - BASE_ADDR;
  assign host_idx   = host_addr - BASE_ADDR;
  assign bus_in     = {1'b0, bus_idx} < DEPTH_L;
  assign host_in    = {1'b0, host_idx} < DEPTH_L;
  assign bus_active = mem_we || (mem_addr != last_addr);
  assign host_ack   = (state_q == H_ACK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data <= '0;
      last_addr     <= '0;
      oor_err       <= 1'b0;
    end else begin
      mem_read_data <= bus_in ? mem[bus_idx[AW-1:0]] : OOR_DATA;
      last_addr     <= mem_addr;
      if (!bus_in)
        oor_err <= 1'b1;
    end
  end

  // Bus write has priority; the host only writes on a quiet bus cycle
  always_ff @(posedge clk) begin
    if (mem_we && bus_in)
      mem[bus_idx[AW-1:0]] <= mem_write_data;
    else if (host_go && host_we && host_in)
      mem[host_idx[AW-1:0]] <= host_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      host_rdata <= '0;
    else if (host_go && !host_we)
      host_rdata <= host_in ? mem[host_idx[AW-1:0]] : OOR_DATA;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= H_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    host_go = 1'b0;
    unique case (state_q)
      H_IDLE: if (host_req) state_d = H_ARB;
      H_ARB: begin
        if (!bus_active) begin
          host_go = 1'b1;
          state_d = H_ACK;
        end
      end
      H_ACK:   state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  res_tracker #(
    .RES_ADDR(RES_ADDR),
    .NUM_RES (NUM_RES)
  ) u_res (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (mem_we),
    .addr    (mem_addr),
    .res_done(res_done)
  );

endmodule

// File: tb/tb_sha_mem_responder.sv
// Directed bench for sha_mem_responder.
// Inputs change 1 time unit after posedge; outputs sampled there.
module tb_sha_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        res_done;
  logic        oor_err;

  int n_tests = 0;
  int n_fail  = 0;

  sha_mem_responder dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .host_ack      (host_ack),
    .res_done      (res_done),
    .oor_err       (oor_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    mem_we         = 1'b1;
    mem_addr       = a;
    mem_write_data = d;
    tick();
    mem_we = 1'b0;
  endtask

  task automatic host_access(input logic we, input logic [15:0] a,
                             input logic [31:0] d,
                             output logic [31:0] rd, output int lat);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
    lat        = 0;
    while (!host_ack && lat < 50) begin
      tick();
      lat++;
    end
    if (!host_ack)
      check("host_timeout", 32'd0, 32'd1);
    rd       = host_rdata;
    host_req = 1'b0;
    tick();
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_rdata"}, mem_read_data, 32'h0);
    check({tag, "_hrdata"}, host_rdata, 32'h0);
    check({tag, "_ack"}, {31'd0, host_ack}, 32'd0);
    check({tag, "_done"}, {31'd0, res_done}, 32'd0);
    check({tag, "_oor"}, {31'd0, oor_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          lat;
    reset_n        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_write_data = '0;
    host_req       = 1'b0;
    host_we        = 1'b0;
    host_addr      = '0;
    host_wdata     = '0;
    tick();
    tick();
    check_zero_outs("reset");
    reset_n = 1'b1;
    tick();

    // host preload, then bus readback
    host_access(1'b1, 16'h0003, 32'h01234567, rd, lat);
    check("preload_lat", lat, 32'd2);
    mem_addr = 16'h0003;
    tick();
    check("bus_rd_3", mem_read_data, 32'h01234567);

    // read-first on a bus write
    bus_wr(16'h0005, 32'h0000000A);
    bus_wr(16'h0005, 32'h0000000B);
    check("rf_old", mem_read_data, 32'h0000000A);
    tick();
    check("rf_new", mem_read_data, 32'h0000000B);

    // result window completion
    for (int i = 0; i < 16; i++) begin
      bus_wr(16'h0080 + 16'(i), 32'h100 + 32'(i));
      check($sformatf("res_done_%0d", i), {31'd0, res_done},
            (i == 15) ? 32'd1 : 32'd0);
    end
    bus_wr(16'h0080, 32'h0000_0F00);
    check("res_rewrite", {31'd0, res_done}, 32'd0);
    tick();
    check("res_quiet", {31'd0, res_done}, 32'd0);

    // host stall behind 4 bus writes
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      bus_wr(16'h0010 + 16'(i), 32'h1000 + 32'(i));
      check($sformatf("stall_ack_%0d", i), {31'd0, host_ack}, 32'd0);
    end
    tick();
    check("stall_ack", {31'd0, host_ack}, 32'd1);
    check("stall_rdata", host_rdata, 32'h00001000);
    host_req = 1'b0;
    tick();
    check("stall_ack_drop", {31'd0, host_ack}, 32'd0);

    // host out-of-range read does not touch oor_err
    host_access(1'b0, 16'h0100, 32'h0, rd, lat);
    check("host_oor_rd", rd, 32'hDEADBEEF);
    check("host_oor_flag", {31'd0, oor_err}, 32'd0);

    // bus out-of-range
    host_access(1'b1, 16'h0000, 32'h0BADF00D, rd, lat);
    mem_addr = 16'h0100;
    tick();
    check("oor_rd", mem_read_data, 32'hDEADBEEF);
    check("oor_flag", {31'd0, oor_err}, 32'd1);
    bus_wr(16'h0100, 32'h00000055);
    mem_addr = 16'h0000;
    tick();
    check("oor_wr_dropped", mem_read_data, 32'h0BADF00D);
    check("oor_sticky", {31'd0, oor_err}, 32'd1);

    // partial run, then reset while host waits in H_ARB
    for (int i = 0; i < 8; i++)
      bus_wr(16'h0080 + 16'(i), 32'(i));
    host_req       = 1'b1;
    host_we        = 1'b1;
    host_addr      = 16'h0030;
    host_wdata     = 32'h12345678;
    mem_we         = 1'b1;
    mem_addr       = 16'h0020;
    mem_write_data = 32'h00002020;
    tick();
    tick();
    check("arb_wait", {31'd0, host_ack}, 32'd0);
    reset_n = 1'b0;
    mem_we  = 1'b0;
    #1;
    check_zero_outs("midrst");
    tick();
    host_req = 1'b0;
    reset_n  = 1'b1;
    tick();
    check("post_rst_ack", {31'd0, host_ack}, 32'd0);
    tick();
    check("post_rst_ack2", {31'd0, host_ack}, 32'd0);

    // upper half first: a stale bitmap would fire early
    for (int i = 0; i < 16; i++) begin
      bus_wr(16'h0080 + 16'((i + 8) % 16), 32'h200 + 32'(i));
      check($sformatf("rerun_done_%0d", i), {31'd0, res_done},
            (i == 15) ? 32'd1 : 32'd0);
    end
    tick();
    check("rerun_quiet", {31'd0, res_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
